// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite configuration master:
// FSM states, response codes and the command bundle.
package axil_pkg;

  localparam int AXIL_AW = 40;
  localparam int AXIL_DW = 32;
  localparam int AXIL_SW = AXIL_DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
  } axil_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic               write;
    logic [AXIL_AW-1:0] addr;
    logic [AXIL_DW-1:0] wdata;
    logic [AXIL_SW-1:0] wstrb;
  } cmd_t;

endpackage

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: one register
// write or read per command, result on a response channel.
module axil_cfg_master
  import axil_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 40,
  parameter int         DATA_WIDTH     = 32,
  parameter int         STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [2:0] PROT           = 3'b000,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  axil_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  timeout_q, timeout_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & m_axil_awready;
  assign w_hs  = wvalid_q & m_axil_wready;

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;

    if (state_q inside {WR, WR_B, RD_A, RD_R}) begin
      if (cnt_q != TMAX) cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd_write) begin
            state_d   = WR;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_A;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs) wvalid_d = 1'b0;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (m_axil_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axil_bresp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          cnt_d       = '0;
          state_d     = RSP;
        end
      end
      RD_A: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m_axil_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axil_rresp;
          rsp_rdata_d = m_axil_rdata;
          rsp_write_d = 1'b0;
          cnt_d       = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A wait that ends on this edge clears the counter first,
    // so only a genuinely saturated wait raises the flag.
    if (cnt_d == TMAX) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign timeout        = timeout_q;

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: doc/axil_cfg_master.md
Name: axil_cfg_master

Overview:
- AXI4-Lite initiator that issues single 32-bit register writes and reads on behalf of an on-chip sequencer, for example the firmware-less boot loader or a host-bridge shim.
- It drives the s_axil_* slave port of cgra4ml_axi2ram and its configuration registers.
- Commands arrive on a valid/ready command channel. Results return on a valid/ready response channel.
- Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 40, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width. Only 32 is supported.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- PROT, 3'b000, constant value driven on awprot and arprot.
- TIMEOUT_CYCLES, 1024, number of cycles spent waiting on the slave before the timeout flag is set.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when asserted together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data. 0 for writes.
- rsp_resp  out  2  bresp or rresp.
- timeout  out  1  sticky flag: a wait has exceeded TIMEOUT_CYCLES.
- m_axil_awaddr/awprot/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready, m_axil_araddr/arprot/arvalid/arready, m_axil_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels, widths per parameters.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State goes to IDLE.
  - All valid and ready outputs are 0, except cmd_ready=1 in IDLE.
  - rsp_rdata, rsp_resp and rsp_write are 0.
  - timeout is 0 and the wait counter is 0.
  - Address and data registers are 0.
- All AXI and response outputs are registered. There are no combinational paths from inputs to outputs, except that cmd_ready is a decode of state==IDLE.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, wdata, wstrb and write.
  - If write, go to WR and, in the next cycle, assert awvalid and wvalid together.
  - If read, go to RD_A and assert arvalid.
- State WR:
  - aw_done and w_done are tracked independently.
  - awvalid drops the cycle after an awready handshake. wvalid drops the cycle after a wready handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - When both are done, assert bready and go to WR_B.
- State WR_B:
  - bready=1.
  - On bvalid, capture bresp into rsp_resp, set rsp_rdata=0 and rsp_write=1, then go to RSP.
- State RD_A:
  - On arready, drop arvalid, assert rready and go to RD_R.
- State RD_R:
  - On rvalid, capture rdata and rresp, set rsp_write=0, then go to RSP.
- State RSP:
  - rsp_valid=1. Response fields are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - A new command is accepted no earlier than the cycle after rsp_ready.
- Best-case latency: command accept to rsp_valid is 3 cycles when the slave is zero-wait (accept, address/data handshake, response capture).
- AXI rules:
  - Once asserted, valid is never deasserted before its handshake.
  - Address, data and strobes remain stable while valid is high.
  - bready and rready are asserted only in their wait states.
- Timeout:
  - The wait counter is cleared on entry to WR, RD_A and RSP. It increments each cycle in WR, WR_B, RD_A and RD_R.
  - It saturates at TIMEOUT_CYCLES, at which point timeout is set.
  - timeout stays set until reset.
  - The FSM keeps waiting; it never abandons an in-flight AXI transaction.
- SLVERR and DECERR responses are passed through in rsp_resp unchanged; no retry.
- Reset mid-transaction: all valids deassert immediately (asynchronous). Recovery of the slave is the system's responsibility.

Decomposition:
- Package axil_pkg:
  - typedef enum for states: IDLE, WR, WR_B, RD_A, RD_R, RSP.
  - Response code constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Command struct {write, addr, wdata, wstrb}.
- Single module, no sub-modules. The timeout counter is inline.

Test Plan:
- Zero-wait write: addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF.
  - awvalid and wvalid rise together one cycle after accept and each drop the cycle after its handshake.
  - rsp_valid is asserted 3 cycles after accept with rsp_resp=0 and rsp_write=1.
- Skewed write: slave holds wready low for 5 cycles after awready.
  - awvalid drops early; wvalid holds wdata=0x12345678 stable until the handshake.
  - bready rises only after both handshakes are done.
- Read: araddr=0x20; slave returns rdata=0xCAFEF00D with rresp=2'b10 after 2 wait cycles.
  - rsp_rdata=0xCAFEF00D, rsp_resp=2'b10, rsp_write=0.
- Response backpressure: rsp_ready held low for 4 cycles.
  - rsp fields stay stable and cmd_ready=0 throughout.
  - The next command is accepted one cycle after rsp_ready.
- Timeout: TIMEOUT_CYCLES=8 and the slave never asserts bvalid.
  - timeout is set once the counter saturates at 8 and stays set.
  - bready remains high; releasing bvalid later completes the write normally.
- Asynchronous reset asserted mid-RD_R.
  - arvalid, rready and rsp_valid are 0 immediately; state is IDLE and cmd_ready=1 after rstn returns high.
